ysyx_23060332_mem_arbiter: RTL and testbench

YSYX_23060332_MEM_ARBITER -- requirements
Module: ysyx_23060332_mem_arbiter

---
 rtl/ysyx_23060332_define.sv | 19 +
 rtl/ysyx_23060332_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_ysyx_23060332_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_define.sv
// Shared encodings for the memory arbiter: FSM states, requester IDs and the tie-break rule.
package ysyx_23060332_define;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic        REQ_IFU = 1'b0;
    localparam logic        REQ_LSU = 1'b1;
    localparam int unsigned MASK_W  = 8;

    // LSU wins when it is the only requester, or on a tie when IFU was served last.
    function automatic logic pick_lsu(input logic ifu_v, input logic lsu_v, input logic last);
        return lsu_v & (~ifu_v | (last == REQ_IFU));
    endfunction

endpackage

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU fetches and LSU loads/stores,
// with a single outstanding transaction and a sticky flag for stray memory responses.
module ysyx_23060332_mem_arbiter
    import ysyx_23060332_define::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_raddr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              proto_err
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]  mem_wmask_q, mem_wmask_d;
    logic               proto_err_q, proto_err_d;
    logic               grant_lsu, ifu_fire, lsu_fire, rsp_fire;

    // Grant is only offered in IDLE; reset forces both readies low immediately.
    always_comb begin : grant_logic
        grant_lsu     = pick_lsu(ifu_req_valid, lsu_req_valid, last_grant_q);
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            ifu_req_ready = ifu_req_valid & ~grant_lsu;
            lsu_req_ready = grant_lsu;
        end
        ifu_fire = ifu_req_valid & ifu_req_ready;
        lsu_fire = lsu_req_valid & lsu_req_ready;
    end

    // Response routed to the owner in the same cycle the memory answers.
    always_comb begin : rsp_route
        rsp_fire      = (state_q == ST_RESP) & mem_rsp_valid;
        ifu_rsp_valid = rsp_fire & (owner_q == REQ_IFU);
        lsu_rsp_valid = rsp_fire & (owner_q == REQ_LSU);
        ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
        lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;
    end

    always_comb begin : next_state
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        proto_err_d  = proto_err_q | (mem_rsp_valid & (state_q != ST_RESP));
        unique case (state_q)
            ST_IDLE: begin
                if (lsu_fire) begin
                    state_d      = ST_REQ;
                    owner_d      = REQ_LSU;
                    last_grant_d = REQ_LSU;
                    mem_wen_d    = lsu_wen;
                    mem_addr_d   = lsu_addr;
                    mem_wdata_d  = lsu_wdata;
                    mem_wmask_d  = lsu_wmask;
                end else if (ifu_fire) begin
                    state_d      = ST_REQ;
                    owner_d      = REQ_IFU;
                    last_grant_d = REQ_IFU;
                    mem_wen_d    = 1'b0;
                    mem_addr_d   = ifu_raddr;
                    mem_wdata_d  = '0;
                    mem_wmask_d  = '0;
                end
            end
            ST_REQ:  if (mem_req_ready) state_d = ST_RESP;
            ST_RESP: if (mem_rsp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_IFU;
            last_grant_q <= REQ_IFU;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_wen       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: a reactive memory model, a round-robin
// reference model and an expected-response queue checked every cycle.
module tb_ysyx_23060332_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_RESP = 2;

    typedef struct packed {
        logic          lsu;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    wmask;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_raddr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic          proto_err;

    ysyx_23060332_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    rsp_t          sb[$];
    cmd_t          exp_cmd;
    logic [DW-1:0] cur_rdata = '0;
    int            m_phase = PH_IDLE;
    int            stall_left = 0, gap_left = 0, cfg_stall = 0, cfg_gap = 0;
    logic          model_last = 1'b0;
    logic          proto_exp = 1'b0;
    logic          spur_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Per-cycle reference: expected grants, payload stability, routing and the sticky error.
    task automatic observe;
        logic busy, g_lsu, g_ifu;
        rsp_t r;
        cmd_t c;
        busy  = (m_phase != PH_IDLE);
        g_lsu = !busy && lsu_req_valid && (!ifu_req_valid || model_last == 1'b0);
        g_ifu = !busy && ifu_req_valid && !g_lsu;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(m_phase == PH_REQ));
        chk("proto_err", 32'(proto_err), 32'(proto_exp));
        if (ifu_req_valid || lsu_req_valid) begin
            chk("ifu_req_ready", 32'(ifu_req_ready), 32'(g_ifu));
            chk("lsu_req_ready", 32'(lsu_req_ready), 32'(g_lsu));
        end
        if (m_phase == PH_REQ) begin
            chk("mem_wen", 32'(mem_wen), 32'(exp_cmd.wen));
            chk("mem_addr", mem_addr, exp_cmd.addr);
            chk("mem_wdata", mem_wdata, exp_cmd.wdata);
            chk("mem_wmask", 32'(mem_wmask), 32'(exp_cmd.wmask));
        end
        if (m_phase == PH_RESP && mem_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(!r.lsu));
                chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(r.lsu));
                chk("rsp_rdata", r.lsu ? lsu_rdata : ifu_rdata, r.data);
            end
        end else begin
            chk("ifu_rsp_idle", 32'(ifu_rsp_valid), 32'd0);
            chk("lsu_rsp_idle", 32'(lsu_rsp_valid), 32'd0);
            chk("ifu_rdata_idle", ifu_rdata, 32'd0);
            chk("lsu_rdata_idle", lsu_rdata, 32'd0);
        end
        if (mem_rsp_valid && m_phase != PH_RESP) proto_exp = 1'b1;
        if (g_lsu || g_ifu) begin
            c.wen   = g_lsu ? lsu_wen : 1'b0;
            c.addr  = g_lsu ? lsu_addr : ifu_raddr;
            c.wdata = g_lsu ? lsu_wdata : '0;
            c.wmask = g_lsu ? lsu_wmask : 8'h00;
            exp_cmd = c;
            cur_rdata = c.wen ? '0 : mem_word(c.addr);
            r.lsu  = g_lsu;
            r.data = cur_rdata;
            sb.push_back(r);
            model_last = g_lsu;
            m_phase    = PH_REQ;
            stall_left = cfg_stall;
        end else if (m_phase == PH_REQ && mem_req_ready) begin
            m_phase  = PH_RESP;
            gap_left = cfg_gap;
        end else if (m_phase == PH_RESP && mem_rsp_valid) begin
            m_phase = PH_IDLE;
        end
    endtask

    // Memory side driven on the falling edge, then the cycle is checked.
    initial begin : mem_side
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = '0;
            if (!rst) begin
                if (m_phase == PH_REQ) begin
                    if (stall_left > 0) stall_left--;
                    else mem_req_ready = 1'b1;
                end else if (m_phase == PH_RESP) begin
                    if (gap_left > 0) gap_left--;
                    else begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata     = cur_rdata;
                    end
                end else if (spur_req) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = 32'hBAD0_BAD0;
                    spur_req      = 1'b0;
                end
            end
            #1;
            if (!rst) observe();
        end
    end

    task automatic apply_reset;
        rst = 1'b1;
        #1;
        chk("rst_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        chk("rst_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
        chk("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        sb.delete();
        m_phase    = PH_IDLE;
        model_last = 1'b0;
        proto_exp  = 1'b0;
        spur_req   = 1'b0;
        stall_left = 0;
        gap_left   = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ifu_fetch(input logic [AW-1:0] a);
        int n;
        n = 0;
        ifu_req_valid = 1'b1;
        ifu_raddr     = a;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!ifu_req_ready && n < 100);
        if (n >= 100) chk("ifu_grant_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [7:0] m);
        int n;
        n = 0;
        lsu_req_valid = 1'b1;
        lsu_wen       = w;
        lsu_addr      = a;
        lsu_wdata     = d;
        lsu_wmask     = m;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!lsu_req_ready && n < 100);
        if (n >= 100) chk("lsu_grant_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((m_phase != PH_IDLE || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin : main
        int n;
        ifu_req_valid = 1'b0;
        ifu_raddr     = '0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        #1;
        apply_reset();

        // Tie from reset goes to LSU; LSU re-requests so the following tie goes to IFU.
        cfg_stall = 0;
        cfg_gap   = 0;
        fork
            ifu_fetch(32'h8000_0100);
            begin
                lsu_op(1'b0, 32'h8000_2000, '0, 8'h00);
                lsu_op(1'b0, 32'h8000_2004, '0, 8'h00);
            end
        join
        wait_idle();

        cfg_gap = 1;
        ifu_fetch(32'h8000_0000);
        wait_idle();

        cfg_stall = 3;
        cfg_gap   = 0;
        lsu_op(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            cfg_stall = int'($urandom_range(0, 2));
            cfg_gap   = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: ifu_fetch(32'h8000_0000 + 32'(i * 4));
                1: lsu_op(1'($urandom_range(0, 1)), 32'h8000_4000 + 32'(i * 8), $urandom, 8'($urandom));
                default: fork
                    ifu_fetch(32'h8000_0040 + 32'(i * 4));
                    lsu_op(1'($urandom_range(0, 1)), 32'h8000_5000 + 32'(i * 8), $urandom, 8'($urandom));
                join
            endcase
            wait_idle();
        end

        // Stray response in IDLE: flag sets, sticks, and nothing is routed.
        spur_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("proto_err_sticky", 32'(proto_err), 32'd1);
        cfg_stall = 0;
        cfg_gap   = 0;
        ifu_fetch(32'h8000_0008);
        wait_idle();

        // Reset during RESP aborts the load; a later response is only a protocol error.
        cfg_gap = 4;
        lsu_op(1'b0, 32'h8000_3000, '0, 8'h00);
        n = 0;
        while (m_phase != PH_RESP && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("reach_resp", 32'(m_phase == PH_RESP), 32'd1);
        apply_reset();
        spur_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("proto_err_after_abort", 32'(proto_err), 32'd1);
        chk("sb_empty_after_abort", 32'(sb.size()), 32'd0);
        apply_reset();
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
